// File: rtl/mci_mcu_rst_req_arb.sv
// Round-robin arbiter that funnels MCU-reset requests into one boot-sequencer handshake and acks the winner.
// Optional completion timeout is enabled by defining MCI_MCU_RST_REQ_TIMEOUT_EN.
module mci_mcu_rst_req_arb #(
  parameter int NUM_REQ       = 3,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       mci_rst,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic                       ack_err_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic                       mcu_rst_req_o,
  input  logic                       seqr_wait_i,
  input  logic                       seqr_rst_active_i,
  output logic                       timeout_o,
  input  logic                       timeout_clr_i
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]      LAST_ID = GW'(NUM_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ACK       = 2'd3
  } state_e;

  state_e               state_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        ptr_q;
  logic                 mask_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 mrr_q;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   req_m;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 win_vld;
  logic [GW-1:0]        win_id_d;
  logic [GW-1:0]        ptr_d;

  assign grant_oh = ONE << grant_q;
  assign ptr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // The just-acked requester is hidden for one IDLE cycle so a late req drop is not regranted.
  assign req_m    = req_i & ~(mask_q ? grant_oh : '0);
  assign req_dbl  = {req_m, req_m} >> ptr_q;
  assign req_rot  = req_dbl[NUM_REQ-1:0];

  always_comb begin
    int sum;
    win_vld  = 1'b0;
    win_id_d = '0;
    sum      = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = int'(ptr_q) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_vld  = 1'b1;
        win_id_d = sum[GW-1:0];
      end
    end
  end

`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     tmo_q;
  logic                     ack_err_q;
  logic                     tmo_hit;

  // Fires on the cycle the counter would step into all-ones and no sequencer progress wins.
  always_comb begin
    tmo_hit = 1'b0;
    if (cnt_q == CNT_LAST) begin
      case (state_q)
        S_REQ:       tmo_hit = !seqr_rst_active_i;
        S_WAIT_DONE: tmo_hit = seqr_rst_active_i || !seqr_wait_i;
        default:     tmo_hit = 1'b0;
      endcase
    end
  end

  assign timeout_o = tmo_q;
  assign ack_err_o = ack_err_q;
`else
  logic unused_tmo;
  assign unused_tmo = timeout_clr_i & (TIMEOUT_WIDTH > 0);
  assign timeout_o  = 1'b0;
  assign ack_err_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge mci_rst) begin
    if (mci_rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      mask_q    <= 1'b0;
      ack_q     <= '0;
      mrr_q     <= 1'b0;
`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
      ack_err_q <= 1'b0;
      if (tmo_hit) begin
        tmo_q <= 1'b1;
      end else if (timeout_clr_i) begin
        tmo_q <= 1'b0;
      end
`endif
      case (state_q)
        S_IDLE: begin
          mask_q <= 1'b0;
          if (seqr_wait_i && win_vld) begin
            grant_q <= win_id_d;
            mrr_q   <= 1'b1;
            state_q <= S_REQ;
`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (seqr_rst_active_i) begin
            mrr_q   <= 1'b0;
            state_q <= S_WAIT_DONE;
`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
            cnt_q   <= cnt_q + 1'b1;
          end else if (tmo_hit) begin
            mrr_q     <= 1'b0;
            ack_q     <= grant_oh;
            ack_err_q <= 1'b1;
            state_q   <= S_ACK;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        S_WAIT_DONE: begin
          // seqr_rst_active_i outranks seqr_wait_i when both are seen together.
          if (seqr_wait_i && !seqr_rst_active_i) begin
            ack_q   <= grant_oh;
            state_q <= S_ACK;
`ifdef MCI_MCU_RST_REQ_TIMEOUT_EN
          end else if (tmo_hit) begin
            ack_q     <= grant_oh;
            ack_err_q <= 1'b1;
            state_q   <= S_ACK;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        S_ACK: begin
          ptr_q   <= ptr_d;
          mask_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          mrr_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign grant_id_o    = grant_q;
  assign busy_o        = (state_q != S_IDLE);
  assign mcu_rst_req_o = mrr_q;

endmodule
